nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 86 ++++++++
 tb/tb_nibble_serial_adder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit slice of a+b+cin per cycle,
// with a valid/ready operand port and a held, registered result.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int NSTEPS = WIDTH / 4;
    localparam int CW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [4:0]       step;
    logic             last;

    assign in_ready = (state == IDLE);
    assign busy     = ~in_ready;

    assign step = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0, carry};
    assign last = (cnt == CW'(NSTEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Step k writes result nibble k; operands shift toward bit 0
                    sum[{cnt, 2'b00} +: 4] <= step[3:0];
                    carry <= step[4];
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        state     <= DONE;
                        cout      <= step[4];
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed cases for WIDTH=16 and 4,
// then random traffic scored against plain a+b+cin arithmetic.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        cin4 = 1'b0;
    logic [3:0]  sum4;
    logic        cout4;
    logic        out_valid4;
    logic        out_ready4 = 1'b0;
    logic        busy4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .sum(sum), .cout(cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4),
        .sum(sum4), .cout(cout4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bounded wait for the 16-bit result; expiry counts as a failure
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(out_valid), 32'd1);
    endtask

    logic [16:0] q[$];
    logic [16:0] expv;
    logic [15:0] hold_sum;
    logic        hold_cout;
    int acc;
    int got;
    int cyc;

    initial begin
        // Reset state
        #3 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // FFFF + 0001: wrap to zero with carry, 5-edge latency
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ovf_busy", 32'(busy), 32'd1);
        chk("ovf_in_ready", 32'(in_ready), 32'd0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("ovf_early_valid", 32'(out_valid), 32'd0);
        end
        tick();
        chk("ovf_valid_5th", 32'(out_valid), 32'd1);
        chk("ovf_sum", 32'(sum), 32'h0000);
        chk("ovf_cout", 32'(cout), 32'd1);
        tick();
        chk("ovf_hs_valid", 32'(out_valid), 32'd0);
        chk("ovf_hs_in_ready", 32'(in_ready), 32'd1);
        chk("ovf_retain", 32'({cout, sum}), 32'h10000);

        // 1234 + 4321 + 1 with back-pressure in DONE
        a = 16'h1234; b = 16'h4321; cin = 1'b1;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            tick();
        end
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_sum", 32'(sum), 32'h5556);
        chk("bp_cout", 32'(cout), 32'd0);
        for (int i = 0; i < 3; i++) begin
            a = ~a; b = b ^ 16'h5A5A;
            tick();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_sum", 32'({cout, sum}), 32'h05556);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("bp_hs_in_ready", 32'(in_ready), 32'd1);
        chk("bp_hs_valid", 32'(out_valid), 32'd0);

        // WIDTH=4: 14 + 10 + 1 -> 9 carry 1 after 2nd edge
        a4 = 4'd14; b4 = 4'd10; cin4 = 1'b1;
        in_valid4 = 1'b1; out_ready4 = 1'b0;
        tick();
        in_valid4 = 1'b0;
        chk("w4_early_valid", 32'(out_valid4), 32'd0);
        tick();
        chk("w4_valid", 32'(out_valid4), 32'd1);
        chk("w4_sum", 32'(sum4), 32'd9);
        chk("w4_cout", 32'(cout4), 32'd1);
        out_ready4 = 1'b1;
        tick();
        chk("w4_hs", 32'(out_valid4), 32'd0);
        chk("w4_in_ready", 32'(in_ready4), 32'd1);

        // Abort mid-RUN by async reset, then a fresh operation
        a = 16'hABCD; b = 16'h1111; cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        #2 rst_n = 1'b1;
        a = 16'h0001; b = 16'h0002; cin = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("after_abort_accept", 32'(busy), 32'd1);
        wait_valid("after_abort_wait");
        chk("after_abort_sum", 32'({cout, sum}), 32'h00003);
        tick();

        // Random traffic against a + b + cin
        acc = 0; got = 0; cyc = 0;
        while ((acc < 1000 || q.size() != 0) && cyc < 50000) begin
            in_valid  = (acc < 1000) && ($urandom_range(0, 3) != 0);
            a         = 16'($urandom);
            b         = 16'($urandom);
            cin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                expv = {1'b0, a} + {1'b0, b} + {16'b0, cin};
                q.push_back(expv);
                acc++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_spurious", 32'd1, 32'd0);
                end else begin
                    expv = q.pop_front();
                    chk("rand_result", 32'({cout, sum}), 32'(expv));
                end
                got++;
            end
            tick();
            cyc++;
        end
        chk("rand_in_budget", 32'(cyc < 50000), 32'd1);
        chk("rand_count", 32'(got), 32'd1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
